// File: rtl/pu_spi_pkg.sv
// pu_spi_pkg
//   Shared constants and types for the PU SPI slave endpoint.
//   - default frame / attribute widths
//   - bit positions inside rx_attr
//   - FSM state encoding
package pu_spi_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ATTR_WIDTH_DEF = 4;

   localparam int INVALID_BIT  = 1;
   localparam int UNDERRUN_BIT = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Two-flop synchroniser for an asynchronous pin followed by a history flop
//   that yields single-cycle rise/fall pulses of the synchronised level.
//   Ports:
//     clk     in   system clock
//     rst     in   asynchronous active-high reset
//     d_i     in   asynchronous input pin
//     sync_o  out  synchronised level (after 2 flops)
//     rise_o  out  one-cycle pulse on a 0->1 of sync_o
//     fall_o  out  one-cycle pulse on a 1->0 of sync_o
//   Parameter RST_VAL sets the reset level of every flop so that no false
//   edge appears when reset releases.
module spi_sync_edge
   import pu_spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/pu_spi_slave.sv
// pu_spi_slave
//   SPI mode-0 slave, MSB first, fully oversampled by clk. Receives MOSI
//   frames into rx_data/rx_attr and shifts the holding-register word out on
//   MISO during the same frame. Back-to-back frames are supported while cs
//   stays low.
//   Ports:
//     clk, rst            system clock, asynchronous active-high reset
//     mosi, sclk, cs      SPI pins from the master (asynchronous, cs active-low)
//     miso                SPI data to the master, driven 0 while idle
//     tx_data, tx_load    write port of the tx holding register
//     tx_ready            holding register empty
//     rx_data, rx_attr    last received word and its status
//     rx_valid            one-cycle pulse when rx_data/rx_attr update
//     busy                frame in progress (synchronised cs low)
//   Build option: PU_SPI_SLAVE_PARTIAL_EN - deliver frames cut short by an
//   early cs rise, left-aligned and flagged with rx_attr[INVALID]. Without
//   it such frames are dropped silently.
//
//   state | meaning
//   IDLE  | cs high, miso held 0, no shifting
//   SHIFT | cs low, shifting frames (loops across frame boundaries)
module pu_spi_slave
   import pu_spi_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ATTR_WIDTH = ATTR_WIDTH_DEF,
   parameter int INVALID    = INVALID_BIT,
   parameter int UNDERRUN   = UNDERRUN_BIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mosi,
   input  logic                  sclk,
   input  logic                  cs,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic [ATTR_WIDTH-1:0] rx_attr,
   output logic                  rx_valid,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] DW_CNT = CNT_W'(DATA_WIDTH);

   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic cs_rise, cs_fall, cs_lvl_unused;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk    (clk),
      .rst    (rst),
      .d_i    (sclk),
      .sync_o (sclk_lvl_unused),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
      .clk    (clk),
      .rst    (rst),
      .d_i    (cs),
      .sync_o (cs_lvl_unused),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk    (clk),
      .rst    (rst),
      .d_i    (mosi),
      .sync_o (mosi_sync),
      .rise_o (mosi_rise_unused),
      .fall_o (mosi_fall_unused)
   );

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  underrun_q, underrun_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [ATTR_WIDTH-1:0] rx_attr_q, rx_attr_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  miso_q, miso_d;
   logic                  consume;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         underrun_q  <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_attr_q   <= '0;
         rx_valid_q  <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         underrun_q  <= underrun_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_attr_q   <= rx_attr_d;
         rx_valid_q  <= rx_valid_d;
         miso_q      <= miso_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      underrun_d = underrun_q;
      rx_data_d  = rx_data_q;
      rx_attr_d  = rx_attr_q;
      rx_valid_d = 1'b0;
      consume    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               consume = 1'b1;
            end
         end
         SHIFT: begin
            // Completion is handled one cycle after the last shift so the
            // full word is already in rx_shift_q.
            if (cnt_q == DW_CNT) begin
               rx_data_d           = rx_shift_q;
               rx_attr_d           = '0;
               rx_attr_d[INVALID]  = 1'b0;
               rx_attr_d[UNDERRUN] = underrun_q;
               rx_valid_d          = 1'b1;
               cnt_d               = '0;
               if (cs_rise) begin
                  state_d = IDLE;
               end else begin
                  consume = 1'b1;
               end
            end else if (cs_rise) begin
               state_d = IDLE;
               cnt_d   = '0;
`ifdef PU_SPI_SLAVE_PARTIAL_EN
               if (cnt_q != '0) begin
                  rx_data_d           = rx_shift_q << (DW_CNT - cnt_q);
                  rx_attr_d           = '0;
                  rx_attr_d[INVALID]  = 1'b1;
                  rx_attr_d[UNDERRUN] = underrun_q;
                  rx_valid_d          = 1'b1;
               end
`endif
            end else begin
               if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                  cnt_d      = cnt_q + 1'b1;
               end
               // A fall before any rise of this frame (i.e. the trailing
               // fall of the previous frame) must not eat the freshly
               // reloaded MSB.
               if (sclk_fall && (cnt_q != '0)) begin
                  tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (consume) begin
         tx_shift_d = hold_full_q ? hold_q : '0;
         underrun_d = ~hold_full_q;
      end

      // Consumption frees the holding register before a same-cycle load.
      hold_d      = hold_q;
      hold_full_d = hold_full_q & ~consume;
      if (tx_load && !hold_full_d) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      miso_d = (state_q == SHIFT) & tx_shift_q[DATA_WIDTH-1];
   end

   assign miso     = miso_q;
   assign tx_ready = ~hold_full_q;
   assign rx_data  = rx_data_q;
   assign rx_attr  = rx_attr_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_pu_spi_slave.sv
// tb_pu_spi_slave
//   Bench for pu_spi_slave: a mode-0 master model drives frames, expected
//   rx words go into a scoreboard queue at stimulus time and are compared
//   when rx_valid pulses; MISO words are compared at the end of each frame.
module tb_pu_spi_slave;

   localparam int DW      = 32;
   localparam int AW      = 4;
   localparam int INV_BIT = 1;
   localparam int UND_BIT = 0;

   logic          clk = 1'b0;
   logic          rst;
   logic          mosi, sclk, cs, miso;
   logic [DW-1:0] tx_data;
   logic          tx_load, tx_ready;
   logic [DW-1:0] rx_data;
   logic [AW-1:0] rx_attr;
   logic          rx_valid, busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int vcount       = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic [AW-1:0] attr;
      logic [AW-1:0] mask;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_pop;

   always #5 clk = ~clk;

   pu_spi_slave dut (
      .clk      (clk),
      .rst      (rst),
      .mosi     (mosi),
      .sclk     (sclk),
      .cs       (cs),
      .miso     (miso),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_attr  (rx_attr),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_tx(input logic [DW-1:0] w);
      tx_data = w;
      tx_load = 1'b1;
      wclk(1);
      tx_load = 1'b0;
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [AW-1:0] m);
      exp_t e;
      e.data = d;
      e.attr = a;
      e.mask = m;
      exp_q.push_back(e);
   endtask

   // Master: mosi set while sclk low, miso captured just before each rise.
   task automatic spi_bits(input logic [DW-1:0] w, input int n, output logic [DW-1:0] rd);
      rd = '0;
      for (int i = 0; i < n; i++) begin
         mosi = w[DW-1-i];
         wclk(5);
         rd   = {rd[DW-2:0], miso};
         sclk = 1'b1;
         wclk(5);
         sclk = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         vcount++;
         check_eq("rx_expected_pending", DW'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e_pop = exp_q.pop_front();
            check_eq("rx_data", rx_data, e_pop.data);
            check_eq("rx_attr", DW'(rx_attr & e_pop.mask), DW'(e_pop.attr & e_pop.mask));
         end
      end
   end

   initial begin
      logic [DW-1:0] rd, rd2;
      int            v0;

      rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tx_data = '0; tx_load = 1'b0;
      wclk(3);
      rst = 1'b0;
      wclk(10);
      check_eq("rst_miso", DW'(miso), 0);
      check_eq("rst_tx_ready", DW'(tx_ready), 1);
      check_eq("rst_rx_valid", DW'(rx_valid), 0);
      check_eq("rst_busy", DW'(busy), 0);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_rx_attr", DW'(rx_attr), 0);

      // Normal frame with a loaded tx word
      load_tx(32'hDEADBEEF);
      check_eq("t1_tx_ready_full", DW'(tx_ready), 0);
      v0 = vcount;
      push_exp(32'h12345678, 4'h0, 4'hF);
      cs = 1'b0;
      wclk(6);
      check_eq("t1_busy", DW'(busy), 1);
      check_eq("t1_tx_ready_after_csfall", DW'(tx_ready), 1);
      spi_bits(32'h12345678, 32, rd);
      wclk(6);
      cs = 1'b1;
      wclk(8);
      check_eq("t1_miso_word", rd, 32'hDEADBEEF);
      check_eq("t1_busy_end", DW'(busy), 0);
      check_eq("t1_miso_idle", DW'(miso), 0);
      check_eq("t1_rx_valid_count", DW'(vcount - v0), 1);

      // Underrun: nothing loaded
      v0 = vcount;
      push_exp(32'hA5A5A5A5, AW'(1 << UND_BIT), 4'hF);
      cs = 1'b0;
      wclk(6);
      spi_bits(32'hA5A5A5A5, 32, rd);
      wclk(6);
      cs = 1'b1;
      wclk(8);
      check_eq("t2_miso_word", rd, 32'h0);
      check_eq("t2_rx_valid_count", DW'(vcount - v0), 1);

      // Back-to-back frames with holding reloaded during the first
      load_tx(32'h11111111);
      v0 = vcount;
      push_exp(32'h0F1E2D3C, 4'h0, 4'hF);
      push_exp(32'h4B5A6978, 4'h0, 4'hF);
      cs = 1'b0;
      wclk(6);
      check_eq("t3_tx_ready_after_csfall", DW'(tx_ready), 1);
      load_tx(32'h22222222);
      check_eq("t3_tx_ready_reloaded", DW'(tx_ready), 0);
      load_tx(32'h33333333);
      spi_bits(32'h0F1E2D3C, 32, rd);
      spi_bits(32'h4B5A6978, 32, rd2);
      wclk(6);
      cs = 1'b1;
      wclk(8);
      check_eq("t3_miso_word0", rd, 32'h11111111);
      check_eq("t3_miso_word1", rd2, 32'h22222222);
      check_eq("t3_rx_valid_count", DW'(vcount - v0), 2);
      check_eq("t3_tx_ready_end", DW'(tx_ready), 1);

      // Partial frame: cs rises after 8 bits
      v0 = vcount;
`ifdef PU_SPI_SLAVE_PARTIAL_EN
      push_exp(32'hFF000000, AW'(1 << INV_BIT), AW'(1 << INV_BIT));
`endif
      cs = 1'b0;
      wclk(6);
      spi_bits(32'hFF000000, 8, rd);
      wclk(6);
      cs = 1'b1;
      wclk(10);
`ifdef PU_SPI_SLAVE_PARTIAL_EN
      check_eq("t4_rx_valid_count", DW'(vcount - v0), 1);
`else
      check_eq("t4_rx_valid_count", DW'(vcount - v0), 0);
      check_eq("t4_busy_end", DW'(busy), 0);
`endif

      // Reset in the middle of a frame, then a clean frame
      load_tx(32'hCAFEF00D);
      v0 = vcount;
      cs = 1'b0;
      wclk(6);
      load_tx(32'h55AA55AA);
      check_eq("t5_tx_ready_full", DW'(tx_ready), 0);
      spi_bits(32'h9876ABCD, 16, rd);
      rst  = 1'b1;
      cs   = 1'b1;
      sclk = 1'b0;
      wclk(2);
      check_eq("t5_tx_ready_in_rst", DW'(tx_ready), 1);
      check_eq("t5_busy_in_rst", DW'(busy), 0);
      rst = 1'b0;
      wclk(10);
      check_eq("t5_rx_valid_count", DW'(vcount - v0), 0);
      check_eq("t5_rx_data_cleared", rx_data, 0);

      load_tx(32'h0F0F0F0F);
      v0 = vcount;
      push_exp(32'h3C3CA5C3, 4'h0, 4'hF);
      cs = 1'b0;
      wclk(6);
      spi_bits(32'h3C3CA5C3, 32, rd);
      wclk(6);
      cs = 1'b1;
      wclk(8);
      check_eq("t6_miso_word", rd, 32'h0F0F0F0F);
      check_eq("t6_rx_valid_count", DW'(vcount - v0), 1);

      wclk(10);
      check_eq("sb_empty", DW'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
